nested_step_counter: RTL

//   Parametrised successor of the single-level step counter: a chain of LEVELS step counters.

---
 rtl/nested_step_counter.sv | 81 ++++++++
 1 files changed

// File: rtl/nested_step_counter.sv
// Chain of LEVELS step counters producing nested loop indices; level 0 is innermost.
// Optional NESTED_STEP_COUNTER_STICKY_DONE_EN: done latches and freezes the nest until clr/reset.
module nested_step_counter #(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 12
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr,
    input  logic                      cnt,
    input  logic [LEVELS*WIDTH-1:0]   max,
    output logic [LEVELS*WIDTH-1:0]   idx,
    output logic [LEVELS-1:0]         last,
    output logic [LEVELS-1:0]         ov,
    output logic                      done
);

    logic [WIDTH-1:0]  idx_p1 [LEVELS];
    logic [LEVELS-1:0] ov_p1;
    logic              done_p1;
    logic [LEVELS-1:0] adv;
    logic [LEVELS-1:0] wrap;
    logic              frozen;

`ifdef NESTED_STEP_COUNTER_STICKY_DONE_EN
    assign frozen = done_p1;
`else
    assign frozen = 1'b0;
`endif

    // >= rather than == so a max lowered below the index still forces a wrap
    always_comb begin
        last = '0;
        adv  = '0;
        for (int i = 0; i < LEVELS; i++) begin
            last[i] = (idx_p1[i] >= max[i*WIDTH +: WIDTH]);
        end
        adv[0] = cnt & ~clr & ~frozen;
        for (int i = 1; i < LEVELS; i++) begin
            adv[i] = adv[i-1] & last[i-1];
        end
        wrap = adv & last;
    end

    // stage p1: registered indices and wrap pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LEVELS; i++) idx_p1[i] <= '0;
            ov_p1   <= '0;
            done_p1 <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < LEVELS; i++) idx_p1[i] <= '0;
            ov_p1   <= '0;
            done_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < LEVELS; i++) begin
                if (adv[i]) begin
                    if (last[i]) idx_p1[i] <= '0;
                    else         idx_p1[i] <= idx_p1[i] + 1'b1;
                end
            end
            ov_p1 <= wrap;
`ifdef NESTED_STEP_COUNTER_STICKY_DONE_EN
            done_p1 <= done_p1 | wrap[LEVELS-1];
`else
            done_p1 <= wrap[LEVELS-1];
`endif
        end
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < LEVELS; i++) begin
            idx[i*WIDTH +: WIDTH] = idx_p1[i];
        end
    end

    assign ov   = ov_p1;
    assign done = done_p1;

endmodule
